// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: NCH-channel PWM, one shared period counter, period/duty double-buffered to period boundaries.
// Optional macro PWM_CENTER_ALIGN_EN adds the mode input for up/down (center-aligned) counting.
module pwm_multi_gen #(
    parameter int NCH   = 4,
    parameter int CBITS = 14,
    parameter int CHW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CBITS-1:0] period,
    input  logic             duty_wr,
    input  logic [CHW-1:0]   duty_ch,
    input  logic [CBITS-1:0] duty_val,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic             mode,
`endif
    output logic [NCH-1:0]   pulse,
    output logic             period_end
);
    logic [CBITS-1:0] cnt, cnt_nx, period_act;
    logic [CBITS-1:0] duty_sh  [NCH];
    logic [CBITS-1:0] duty_act [NCH];
    logic             wrap;
`ifdef PWM_CENTER_ALIGN_EN
    logic dir, dir_nx, mode_act, turn;
    // dir=1 is the down phase; it wraps at 1 so cnt=0 is visited once per period
    always_comb begin
        turn   = mode_act && !dir && cnt == period_act;
        wrap   = en && (mode_act ? (dir ? cnt == CBITS'(1) : (period_act <= CBITS'(1) && cnt == period_act))
                                 : cnt == period_act);
        dir_nx = !wrap && (dir || turn);
        cnt_nx = wrap ? '0 : (dir_nx ? cnt - CBITS'(1) : cnt + CBITS'(1));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir      <= 1'b0;
            mode_act <= 1'b0;
        end else begin
            dir <= en && dir_nx;
            if (!en || wrap) mode_act <= mode;
        end
    end
`else
    always_comb begin
        wrap   = en && cnt == period_act;
        cnt_nx = wrap ? '0 : cnt + CBITS'(1);
    end
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            period_act <= '0;
            pulse      <= '0;
            period_end <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (duty_wr && int'(duty_ch) == i) duty_sh[i] <= duty_val;
                pulse[i] <= en && (cnt < duty_act[i]);
                if (!en || wrap) duty_act[i] <= duty_sh[i];
            end
            if (!en || wrap) period_act <= period;
            period_end <= wrap;
            cnt        <= en ? cnt_nx : '0;
        end
    end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: table vectors, directed multi-period sequences and random stimulus
// checked every cycle against a period-position reference model.
module tb_pwm_multi_gen;
    localparam int NCH = 4, CBITS = 8, CHW = 3;
`ifdef PWM_CENTER_ALIGN_EN
    localparam bit CENTER = 1'b1;
`else
    localparam bit CENTER = 1'b0;
`endif
    logic             clk = 1'b0;
    logic             rst_n, en, duty_wr, mode;
    logic [CBITS-1:0] period, duty_val;
    logic [CHW-1:0]   duty_ch;
    logic [NCH-1:0]   pulse;
    logic             period_end;
    int vectors = 0, miscompares = 0;
    int m_pos, m_per, m_mode;
    int m_duty [NCH];
    int m_sh   [NCH];
    logic [NCH-1:0] m_pulse;
    logic           m_pe;
    int win_hi [NCH];
    int win_pe;
    typedef struct {
        logic             rst_n, en, wr;
        logic [CHW-1:0]   ch;
        logic [CBITS-1:0] val;
        logic [NCH-1:0]   exp_pulse;
        logic             exp_pe;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    pwm_multi_gen #(.NCH(NCH), .CBITS(CBITS), .CHW(CHW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .period(period),
        .duty_wr(duty_wr),
        .duty_ch(duty_ch),
        .duty_val(duty_val),
`ifdef PWM_CENTER_ALIGN_EN
        .mode(mode),
`endif
        .pulse(pulse),
        .period_end(period_end)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model tracks the position inside the current period; cnt is derived from it.
    task automatic model_step();
        int  c, len;
        logic wrap;
        if (!rst_n) begin
            m_pos = 0; m_per = 0; m_mode = 0; m_pulse = '0; m_pe = 1'b0;
            for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_sh[i] = 0; end
        end else begin
            len  = m_mode != 0 ? ((2 * m_per > 1) ? 2 * m_per : 1) : m_per + 1;
            c    = (m_mode != 0 && m_pos > m_per) ? 2 * m_per - m_pos : m_pos;
            wrap = en && (m_pos == len - 1);
            for (int i = 0; i < NCH; i++) m_pulse[i] = en && (c < m_duty[i]);
            m_pe = wrap;
            if (!en || wrap) begin
                m_per  = int'(period);
                m_mode = (CENTER && mode) ? 1 : 0;
                for (int i = 0; i < NCH; i++) m_duty[i] = m_sh[i];
            end
            if (duty_wr && int'(duty_ch) < NCH) m_sh[int'(duty_ch)] = int'(duty_val);
            m_pos = (!en || wrap) ? 0 : m_pos + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pulse", {28'd0, pulse}, {28'd0, m_pulse});
        check("period_end", {31'd0, period_end}, {31'd0, m_pe});
    endtask

    task automatic window(input int len, input int wr_at, input int wc, input int wv);
        win_pe = 0;
        for (int i = 0; i < NCH; i++) win_hi[i] = 0;
        for (int k = 0; k < len; k++) begin
            duty_wr  = (k == wr_at);
            duty_ch  = CHW'(wc);
            duty_val = CBITS'(wv);
            tick();
            duty_wr = 1'b0;
            for (int i = 0; i < NCH; i++) if (pulse[i]) win_hi[i]++;
            if (period_end) win_pe++;
        end
    endtask

    task automatic until_pe(output int n);
        n = 0;
        do begin tick(); n++; end while (period_end !== 1'b1 && n < 64);
    endtask

    task automatic check_win(input string name, input int h0, input int h1, input int h2, input int h3);
        check({name, "_ch0"}, win_hi[0], h0);
        check({name, "_ch1"}, win_hi[1], h1);
        check({name, "_ch2"}, win_hi[2], h2);
        check({name, "_ch3"}, win_hi[3], h3);
    endtask

    function automatic vec_t mk(input int r, input int e, input int w, input int c, input int v,
                                input int p, input int pe);
        vec_t t;
        t.rst_n = (r != 0); t.en = (e != 0); t.wr = (w != 0);
        t.ch = CHW'(c); t.val = CBITS'(v); t.exp_pulse = NCH'(p); t.exp_pe = (pe != 0);
        return t;
    endfunction

    initial begin
        int n;
        tbl[0]  = mk(0, 1, 0, 0, 0, 'b0000, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 'b0000, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 'b0000, 0);
        tbl[3]  = mk(1, 0, 1, 0, 2, 'b0000, 0);
        tbl[4]  = mk(1, 0, 1, 1, 4, 'b0000, 0);
        tbl[5]  = mk(1, 0, 1, 3, 1, 'b0000, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 'b0000, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 'b1011, 0);
        tbl[8]  = mk(1, 1, 0, 0, 0, 'b0011, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 'b0010, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 'b0010, 1);
        tbl[11] = mk(1, 1, 0, 0, 0, 'b1011, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 'b0000, 0);
        tbl[13] = mk(1, 1, 0, 0, 0, 'b1011, 0);
        tbl[14] = mk(1, 1, 0, 0, 0, 'b0011, 0);
        tbl[15] = mk(0, 1, 0, 0, 0, 'b0000, 0);
        tbl[16] = mk(1, 1, 0, 0, 0, 'b0000, 1);
        tbl[17] = mk(1, 1, 0, 0, 0, 'b0000, 0);
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; period = 8'd3;
        duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
        for (int r = 0; r < 18; r++) begin
            rst_n = tbl[r].rst_n; en = tbl[r].en; duty_wr = tbl[r].wr;
            duty_ch = tbl[r].ch; duty_val = tbl[r].val;
            tick();
            check($sformatf("tbl%0d_pulse", r), {28'd0, pulse}, {28'd0, tbl[r].exp_pulse});
            check($sformatf("tbl%0d_pe", r), {31'd0, period_end}, {31'd0, tbl[r].exp_pe});
        end
        duty_wr = 1'b0;

        en = 1'b0; period = 8'd9;
        window(1, 0, 0, 3);
        window(1, 0, 1, 0);
        window(1, 0, 2, 10);
        window(1, 0, 3, 5);
        window(1, -1, 0, 0);
        en = 1'b1;
        until_pe(n);
        check("align_start", n, 10);
        window(10, -1, 0, 0);
        check_win("mix", 3, 0, 10, 5);
        check("mix_pe", win_pe, 1);

        window(10, 4, 0, 7);
        check("midwr_cur", win_hi[0], 3);
        window(10, -1, 0, 0);
        check("midwr_next", win_hi[0], 7);
        window(10, 9, 0, 2);
        check("wrapwr_cur", win_hi[0], 7);
        window(10, -1, 0, 0);
        check("wrapwr_next", win_hi[0], 7);
        window(10, -1, 0, 0);
        check("wrapwr_late", win_hi[0], 2);

        for (int p = 0; p < 3; p++) begin
            window(10, p == 0 ? 0 : -1, 5, 8);
            check_win($sformatf("badch_p%0d", p), 2, 0, 10, 5);
        end

        window(3, -1, 0, 0);
        period = 8'd4;
        until_pe(n);
        check("old_period_len", n, 7);
        until_pe(n);
        check("new_period_len", n, 5);
        window(2, -1, 0, 0);
        en = 1'b0;
        tick();
        check("en_off_pulse", {28'd0, pulse}, 32'd0);
        tick();
        en = 1'b1;
        window(5, -1, 0, 0);
        check("reen_ch0", win_hi[0], 2);
        check("reen_ch2", win_hi[2], 5);

`ifdef PWM_CENTER_ALIGN_EN
        en = 1'b0; mode = 1'b1; period = 8'd4;
        window(1, 0, 0, 2);
        window(1, -1, 0, 0);
        en = 1'b1;
        until_pe(n);
        check("ctr_align", n, 8);
        for (int p = 0; p < 2; p++) begin
            window(8, -1, 0, 0);
            check($sformatf("ctr_ch0_p%0d", p), win_hi[0], 3);
            check($sformatf("ctr_pe_p%0d", p), win_pe, 1);
        end
        mode = 1'b0;
`endif

        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(63) != 0);
            en    = ($urandom_range(15) != 0);
            if ($urandom_range(31) == 0) period = CBITS'($urandom_range(12));
            if ($urandom_range(63) == 0) mode = ($urandom_range(1) != 0);
            duty_wr  = ($urandom_range(3) == 0);
            duty_ch  = CHW'($urandom_range(7));
            duty_val = CBITS'($urandom_range(14));
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator. It is the next generation of the single-counter, fixed-threshold PWM block.
- One shared free-running period counter drives NCH independent comparators.
- Period and per-channel duty are runtime-programmable.
- Updates are double-buffered and take effect only at a period boundary, so outputs never glitch.
- Sits between a register/switch front end and LED/motor drive pins.

Parameters:
NCH, 4, number of PWM channels (1..16)
CBITS, 14, counter, period and duty width in bits (2..32)
CHW, 2, width of channel-select index; must satisfy 2**CHW >= NCH

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  run enable; 0 = outputs idle, counter held at 0
period  in  CBITS  terminal count; edge-aligned PWM period = period+1 cycles
duty_wr  in  1  one-cycle write strobe for duty shadow register
duty_ch  in  CHW  channel index for duty_wr
duty_val  in  CBITS  duty value (high cycles per period)
pulse  out  NCH  registered PWM outputs, bit i = channel i
period_end  out  1  registered one-cycle strobe, one per completed period
mode  in  1  0 = edge-aligned, 1 = center-aligned; present only with PWM_CENTER_ALIGN_EN

Behaviour:
- Reset (rst_n=0 at clk edge) clears the following regardless of en:
  - cnt=0, dir=up, period_act=0, period_end=0, pulse=0.
  - All duty_sh and duty_act = 0.
- Reset mid-period aborts the period immediately; there is no partial-period completion.
- Wrap event, edge mode: en=1 and cnt==period_act.
- On a wrap event:
  - cnt<=0.
  - period_act<=period.
  - duty_act[i]<=duty_sh[i] for every channel, taking the pre-write shadow value.
  - period_end<=1 on the next edge.
- Otherwise, with en=1: cnt<=cnt+1 and period_end<=0.
- Counter arithmetic is unsigned CBITS wide. cnt never exceeds period_act, so there is no natural overflow.
- Because period_act resets to 0, the first en=1 cycle after reset is a wrap that loads period and duty.
- pulse[i]<=en & (cnt < duty_act[i]), unsigned compare. The output lags the counter by 1 cycle.
- Duty boundary cases:
  - duty_act=0: output constantly low.
  - duty_act>period_act: output constantly high, 100%.
  - period_act=0: period is 1 cycle and wraps every cycle; output is high only if duty_act>=1.
- Duty write: duty_wr=1 with duty_ch<NCH sets duty_sh[duty_ch]<=duty_val.
- A write with duty_ch>=NCH is ignored; no state changes.
- A write in the same cycle as a wrap lands in the shadow and applies at the following wrap.
- period input is sampled only at wrap. Changing it mid-period has no effect until the next boundary.
- en=0:
  - cnt<=0, dir<=up, pulse<=0, period_end<=0.
  - period_act<=period and duty_act<=duty_sh continuously, so values are fresh on re-enable.
  - duty writes are still accepted.
- Re-enable starts at cnt=0 with the loaded values. The first pulse edge appears 1 cycle after en rises.

Optional Feature:
Macro: PWM_CENTER_ALIGN_EN
- Defined:
  - The mode port exists.
  - mode=0 behaves exactly as edge mode.
  - mode=1 (up/down count):
    - Up phase: cnt counts 0..period_act, then dir<=down.
    - Down phase: cnt counts period_act-1..1.
    - Wrap event is cnt==1 with dir=down, or period_act<=1 while at cnt==period_act; this sets cnt<=0, dir<=up and reloads.
    - Period = 2*period_act cycles, with a minimum of 1.
  - Same compare and same lag, so pulses are symmetric about cnt=0.
  - mode is sampled only at wrap or while en=0.
- Undefined: the mode port is absent, there is no dir register, and the block is edge mode only.

Test Plan:
1. CBITS=8, NCH=4; hold rst_n=0 3 cycles, en=1 -> pulse=4'b0000, period_end=0 throughout. Release reset; assert rst_n=0 again mid-period -> pulse=0 on the next edge and the counter restarts from 0.
2. period=9, duty ch0=3, ch1=0, ch2=10, ch3=5, then en=1 -> per 10-cycle window:
   - ch0 high 3 cycles, ch1 never high, ch2 always high, ch3 high 5 cycles.
   - period_end pulses every 10 cycles.
3. period=9, ch0=3 running; write ch0=7 when cnt=4 -> current period still 3 high cycles, every later period 7. Repeat the write exactly on the wrap cycle -> applies one period later.
4. duty_wr with duty_ch=5 (NCH=4, CHW=3), duty_val=8 -> no output change on any channel for 3 periods.
5. Change period 9->4 mid-period, then deassert en at cnt=2 ->
   - The old period completes with 10 cycles; the next period is 5 cycles.
   - pulse=0 and cnt=0 on the edge after en drops.
   - Re-enable -> ch0 high for the first min(duty,5) cycles.
6. PWM_CENTER_ALIGN_EN, mode=1, period=4, ch0 duty=2 -> cnt sequence 0,1,2,3,4,3,2,1 repeating. ch0 is high 3 of every 8 cycles, centered on cnt=0, and period_end fires every 8 cycles.
